// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared FIFO helpers: pointer-width derivation and depth legality check,
// common to the synchronous controller and future asynchronous variants.
package fifo_sync_ctrl_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 16;

    // One extra MSB distinguishes full from empty when the low bits match.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_memory.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// show-ahead read port addressed by the pointer low bits.
module fifo_memory
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
    parameter int PTR_WIDTH = fifo_ptr_width(DEPTH)
) (
    input  logic                 WCLK,
    input  logic                 W_EN,
    input  logic                 FULL,
    input  logic                 empty_in,
    input  logic [PTR_WIDTH-2:0] W_ADDR,
    input  logic [WIDTH-1:0]     W_DI,
    input  logic [PTR_WIDTH-2:0] R_ADDR,
    output logic [WIDTH-1:0]     R_DO
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; stale contents are never observable because
    // the pointers gate every read, and a reset port would block RAM inference.
    always_ff @(posedge WCLK) begin
        if (W_EN && !FULL) begin
            mem_q[W_ADDR] <= W_DI;
        end
    end

    // Drive a clean zero while empty instead of whatever the stale slot holds.
    assign R_DO = empty_in ? '0 : mem_q[R_ADDR];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: owns the wrap-bit pointers, gates writes into
// fifo_memory, and decodes level flags and sticky error flags.
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH     = FIFO_DEFAULT_DEPTH,
    parameter int PTR_WIDTH = fifo_ptr_width(DEPTH),
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 W_EN,
    input  logic [WIDTH-1:0]     W_DI,
    input  logic                 R_EN,
    output logic [WIDTH-1:0]     R_DO,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 ALMOST_FULL,
    output logic                 ALMOST_EMPTY,
    output logic [PTR_WIDTH-1:0] COUNT,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW,
    input  logic                 CLR_ERR
);

    if (!fifo_depth_ok(DEPTH) || (PTR_WIDTH != fifo_ptr_width(DEPTH))) begin : g_bad_param
        $error("fifo_sync_ctrl: DEPTH must be a power of 2 >= 2 and PTR_WIDTH = log2(DEPTH)+1");
    end

    localparam logic [PTR_WIDTH-1:0] AFULL_W  = PTR_WIDTH'(AFULL_TH);
    localparam logic [PTR_WIDTH-1:0] AEMPTY_W = PTR_WIDTH'(AEMPTY_TH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [PTR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 wr_ok, rd_ok;

    // Status is a pure decode of the registered pointers, so it never follows
    // W_EN/R_EN combinationally.
    assign EMPTY        = (w_ptr_q == r_ptr_q);
    assign FULL         = (w_ptr_q[PTR_WIDTH-1] != r_ptr_q[PTR_WIDTH-1]) &&
                          (w_ptr_q[PTR_WIDTH-2:0] == r_ptr_q[PTR_WIDTH-2:0]);
    assign COUNT        = w_ptr_q - r_ptr_q;
    assign ALMOST_FULL  = (COUNT >= AFULL_W);
    assign ALMOST_EMPTY = (COUNT <= AEMPTY_W);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

    assign wr_ok = W_EN && !FULL;
    assign rd_ok = R_EN && !EMPTY;

    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (wr_ok) w_ptr_d = w_ptr_q + PTR_ONE;
        if (rd_ok) r_ptr_d = r_ptr_q + PTR_ONE;
        if (CLR_ERR) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        // Setting is evaluated after clearing so a coincident error is kept.
        if (W_EN && FULL)  ovf_d = 1'b1;
        if (R_EN && EMPTY) unf_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_memory #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .WCLK     (CLK),
        .W_EN     (wr_ok),
        .FULL     (FULL),
        .empty_in (EMPTY),
        .W_ADDR   (w_ptr_q[PTR_WIDTH-2:0]),
        .W_DI     (W_DI),
        .R_ADDR   (r_ptr_q[PTR_WIDTH-2:0]),
        .R_DO     (R_DO)
    );

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_fifo_sync_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 5;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             W_EN;
    logic [WIDTH-1:0] W_DI;
    logic             R_EN;
    logic             CLR_ERR;
    logic [WIDTH-1:0] R_DO;
    logic             FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
    logic [PW-1:0]    COUNT;
    logic             OVERFLOW, UNDERFLOW;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, errors as plain bits.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf, m_unf;

    fifo_sync_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AFULL_TH(12), .AEMPTY_TH(2)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .W_EN(W_EN), .W_DI(W_DI), .R_EN(R_EN), .R_DO(R_DO),
        .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one clock: update the model from the inputs seen at the edge,
    // then return at the falling edge where outputs are sampled.
    task automatic step();
        bit was_full, was_empty;
        @(posedge CLK);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (!RSTN) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (CLR_ERR) begin m_ovf = 0; m_unf = 0; end
            if (W_EN && was_full)  m_ovf = 1;
            if (R_EN && was_empty) m_unf = 1;
            if (R_EN && !was_empty) void'(m_q.pop_front());
            if (W_EN && !was_full)  m_q.push_back(W_DI);
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        W_EN = 0; R_EN = 0; CLR_ERR = 0; W_DI = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RSTN = 0;
        step();
        step();
        RSTN = 1;
        step();
        n_cmp++;
        if ({EMPTY, FULL, COUNT, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW} !==
            {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got E=%b F=%b C=%0d AE=%b AF=%b OV=%b UN=%b, want E=1 F=0 C=0 AE=1 AF=0 OV=0 UN=0",
                     EMPTY, FULL, COUNT, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            W_EN = 1; W_DI = 8'(i);
            step();
            n_cmp++;
            if ({COUNT, FULL, ALMOST_FULL} !== {5'(i + 1), (i == DEPTH - 1), (i + 1 >= 12)}) begin
                n_err++;
                $display("FAIL fill_%0d: got C=%0d F=%b AF=%b, want C=%0d F=%b AF=%b",
                         i, COUNT, FULL, ALMOST_FULL, i + 1, (i == DEPTH - 1), (i + 1 >= 12));
            end
        end
        W_EN = 0;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if ({EMPTY, R_DO} !== {1'b0, 8'(i)}) begin
                n_err++;
                $display("FAIL drain_%0d: got E=%b R_DO=%02h, want E=0 R_DO=%02h", i, EMPTY, R_DO, i);
            end
            R_EN = 1;
            step();
        end
        R_EN = 0;
        n_cmp++;
        if ({EMPTY, COUNT, ALMOST_EMPTY} !== {1'b1, 5'd0, 1'b1}) begin
            n_err++;
            $display("FAIL drain_end: got E=%b C=%0d AE=%b, want E=1 C=0 AE=1", EMPTY, COUNT, ALMOST_EMPTY);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) begin
            W_EN = 1; W_DI = 8'($urandom_range(0, 8'h9F));
            step();
        end
        W_EN = 1; R_EN = 1; W_DI = 8'hAA;
        step();
        idle_inputs();
        n_cmp++;
        if ({COUNT, OVERFLOW, FULL} !== {5'd15, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL full_rw: got C=%0d OV=%b F=%b, want C=15 OV=1 F=0", COUNT, OVERFLOW, FULL);
        end
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (R_DO === 8'hAA || R_DO !== m_q[0]) begin
                n_err++;
                $display("FAIL full_rw_data_%0d: got %02h, want %02h (never AA)", i, R_DO, m_q[0]);
            end
            R_EN = 1;
            step();
        end
        R_EN = 0; CLR_ERR = 1;
        step();
        CLR_ERR = 0;
        n_cmp++;
        if ({OVERFLOW, EMPTY} !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_clear: got OV=%b E=%b, want OV=0 E=1", OVERFLOW, EMPTY);
        end
    endtask

    task automatic test_empty_rw();
        W_EN = 1; R_EN = 1; W_DI = 8'h55;
        step();
        idle_inputs();
        n_cmp++;
        if ({UNDERFLOW, COUNT, EMPTY, R_DO} !== {1'b1, 5'd1, 1'b0, 8'h55}) begin
            n_err++;
            $display("FAIL empty_rw: got UN=%b C=%0d E=%b R_DO=%02h, want UN=1 C=1 E=0 R_DO=55",
                     UNDERFLOW, COUNT, EMPTY, R_DO);
        end
        R_EN = 1;
        step();
        R_EN = 1; CLR_ERR = 1;
        step();
        n_cmp++;
        if ({UNDERFLOW, EMPTY} !== 2'b11) begin
            n_err++;
            $display("FAIL set_beats_clear: got UN=%b E=%b, want UN=1 E=1", UNDERFLOW, EMPTY);
        end
        R_EN = 0;
        step();
        CLR_ERR = 0;
        n_cmp++;
        if (UNDERFLOW !== 1'b0) begin
            n_err++;
            $display("FAIL unf_clear: got UN=%b, want UN=0", UNDERFLOW);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            W_EN = 1; W_DI = pat; pat++;
            step();
        end
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (R_DO !== 8'(i)) begin
                n_err++;
                $display("FAIL wrap_data_%0d: got %02h, want %02h", i, R_DO, 8'(i));
            end
            W_EN = 1; R_EN = 1; W_DI = pat; pat++;
            step();
            n_cmp++;
            if (COUNT !== 5'd8) begin
                n_err++;
                $display("FAIL wrap_count_%0d: got %0d, want 8", i, COUNT);
            end
        end
        W_EN = 0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (R_DO !== 8'(40 + i)) begin
                n_err++;
                $display("FAIL wrap_tail_%0d: got %02h, want %02h", i, R_DO, 8'(40 + i));
            end
            R_EN = 1;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            W_EN = 1; W_DI = 8'(8'hE0 + i);
            step();
        end
        RSTN = 0; W_DI = 8'hE3;
        step();
        RSTN = 1; W_EN = 0;
        n_cmp++;
        if ({EMPTY, FULL, COUNT, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW} !==
            {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: got E=%b F=%b C=%0d AE=%b AF=%b OV=%b UN=%b, want reset values",
                     EMPTY, FULL, COUNT, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW);
        end
        W_EN = 1; W_DI = 8'h3C;
        step();
        W_EN = 0;
        n_cmp++;
        if ({COUNT, R_DO} !== {5'd1, 8'h3C}) begin
            n_err++;
            $display("FAIL after_reset_write: got C=%0d R_DO=%02h, want C=1 R_DO=3C", COUNT, R_DO);
        end
        R_EN = 1;
        step();
        R_EN = 0;
        n_cmp++;
        if (EMPTY !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_read: got E=%b, want E=1", EMPTY);
        end
    endtask

    task automatic test_random();
        int sz;
        for (int i = 0; i < 800; i++) begin
            RSTN    = ($urandom_range(0, 199) != 0);
            W_EN    = ($urandom_range(0, 99) < 55);
            R_EN    = ($urandom_range(0, 99) < 45);
            CLR_ERR = ($urandom_range(0, 29) == 0);
            W_DI    = 8'($urandom);
            step();
            sz = m_q.size();
            n_cmp++;
            if ({FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW} !==
                {(sz == DEPTH), (sz == 0), (sz >= 12), (sz <= 2), 5'(sz), m_ovf, m_unf}) begin
                n_err++;
                $display("FAIL rand_status_%0d: got F=%b E=%b AF=%b AE=%b C=%0d OV=%b UN=%b, want size=%0d OV=%b UN=%b",
                         i, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW, sz, m_ovf, m_unf);
            end
            if (sz != 0) begin
                n_cmp++;
                if (R_DO !== m_q[0]) begin
                    n_err++;
                    $display("FAIL rand_data_%0d: got %02h, want %02h", i, R_DO, m_q[0]);
                end
            end
        end
        RSTN = 1;
        idle_inputs();
    endtask

    initial begin
        RSTN = 0;
        idle_inputs();
        @(negedge CLK);
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
